// File: rtl/debug_cmd_driver.sv
// debug_cmd_driver
//   Host-side initiator for the debug harness. It accepts one high-level request
//   at a time (run, single-step, step-clock, load code bytes, clear ROM, reset DUT).
//   It drives the matching harness signalling and waits for command_complete
//   with a timeout. Each request gets exactly one status response.
//
// State table
//   state     | meaning
//   DUT_RST   | dut_reset_n held low for RESET_HOLD_CYCLES; then IDLE (power-on) or RESP
//   IDLE      | ready for a request, harness quiet
//   ISSUE     | debug_cmd carries the opcode for this single cycle
//   WAIT      | counting cycles until command_complete or timeout
//   LOAD      | CPU held in reset while bytes are written into the code ROM
//   CLR       | reset_code_rom_n low for this single cycle
//   RESP      | response held until rsp_ready
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   req_*               request handshake: op, LOAD base address, LOAD length
//   byte_*              LOAD byte stream handshake
//   rsp_*               response handshake: status (0 OK, 1 TIMEOUT, 2 BAD_OP), cycles
//   debug_cmd           harness command, non-zero only in ISSUE
//   command_complete    harness completion pulse
//   program_rom_mode, code_rom_addr_in, code_rom_data_in   ROM write port
//   reset_code_rom_n    ROM clear, active-low
//   dut_reset_n         harness/DUT reset, active-low
//
// All harness-side outputs are registered from the next-state decode. As a
// result, each output is aligned with the state it belongs to and is glitch-free.
// The WAIT counter is 16 bits wide, so TIMEOUT_CYCLES is meaningful up to 65536.

module debug_cmd_driver #(
    parameter int TIMEOUT_CYCLES    = 65535,
    parameter int RESET_HOLD_CYCLES = 4,
    parameter int ADDR_W            = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_base,
    input  logic [ADDR_W:0]   req_len,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic [7:0]        byte_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_status,
    output logic [15:0]       rsp_cycles,
    output logic [3:0]        debug_cmd,
    input  logic              command_complete,
    output logic              program_rom_mode,
    output logic [ADDR_W-1:0] code_rom_addr_in,
    output logic [7:0]        code_rom_data_in,
    output logic              reset_code_rom_n,
    output logic              dut_reset_n
);

    localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT   = HOLD_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);
    localparam logic [16:0]       TIMEOUT_LIM = 17'(TIMEOUT_CYCLES);
    localparam logic [ADDR_W:0]   IDX_ONE     = (ADDR_W + 1)'(1);

    localparam logic [2:0] OP_RUN   = 3'd1;
    localparam logic [2:0] OP_STEPI = 3'd2;
    localparam logic [2:0] OP_STEPC = 3'd3;
    localparam logic [2:0] OP_LOAD  = 3'd4;
    localparam logic [2:0] OP_CLR   = 3'd5;
    localparam logic [2:0] OP_RST   = 3'd6;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_TIMEOUT = 2'd1;
    localparam logic [1:0] ST_BAD_OP  = 2'd2;

    typedef enum logic [2:0] {
        S_DUT_RST = 3'd0,
        S_IDLE    = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_LOAD    = 3'd4,
        S_CLR     = 3'd5,
        S_RESP    = 3'd6
    } state_t;

    state_t              state, state_next;
    logic [HOLD_W-1:0]   hold_q, hold_next;
    logic                after_rst_q, after_rst_next;
    logic [15:0]         cnt_q, cnt_next;
    logic [ADDR_W:0]     idx_q, idx_next;
    logic [ADDR_W-1:0]   base_q, base_next;
    logic [ADDR_W:0]     len_q, len_next;
    logic [1:0]          status_q, status_next;
    logic [15:0]         cycles_q, cycles_next;
    logic [3:0]          cmd_next;
    logic                prog_next;
    logic [ADDR_W-1:0]   addr_next;
    logic [7:0]          data_next;
    logic                rom_n_next;
    logic                dut_rst_n_next;

    assign req_ready  = (state == S_IDLE);
    assign byte_ready = (state == S_LOAD) && (idx_q != len_q);
    assign rsp_valid  = (state == S_RESP);
    assign rsp_status = status_q;
    assign rsp_cycles = cycles_q;

    always_comb begin
        state_next     = state;
        hold_next      = hold_q;
        after_rst_next = after_rst_q;
        cnt_next       = cnt_q;
        idx_next       = idx_q;
        base_next      = base_q;
        len_next       = len_q;
        status_next    = status_q;
        cycles_next    = cycles_q;
        cmd_next       = 4'd0;
        prog_next      = 1'b0;
        addr_next      = code_rom_addr_in;
        data_next      = code_rom_data_in;

        case (state)
            S_DUT_RST: begin
                if (hold_q == '0) begin
                    // Power-on recovery returns silently; request/timeout recovery answers.
                    state_next     = after_rst_q ? S_RESP : S_IDLE;
                    after_rst_next = 1'b0;
                end else begin
                    hold_next = hold_q - HOLD_ONE;
                end
            end
            S_IDLE: begin
                if (req_valid) begin
                    base_next   = req_base;
                    len_next    = req_len;
                    idx_next    = '0;
                    status_next = ST_OK;
                    cycles_next = 16'd0;
                    case (req_op)
                        OP_RUN, OP_STEPI, OP_STEPC: begin
                            state_next = S_ISSUE;
                            cmd_next   = {1'b0, req_op};
                        end
                        OP_LOAD: begin
                            state_next = (req_len == '0) ? S_RESP : S_LOAD;
                        end
                        OP_CLR: begin
                            state_next = S_CLR;
                        end
                        OP_RST: begin
                            state_next     = S_DUT_RST;
                            hold_next      = HOLD_INIT;
                            after_rst_next = 1'b1;
                        end
                        default: begin
                            state_next  = S_RESP;
                            status_next = ST_BAD_OP;
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                cnt_next   = 16'd0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // cnt_q + 1 is the number of cycles elapsed since the ISSUE cycle.
                // Completion is tested first so it wins over a coincident timeout.
                if (command_complete) begin
                    state_next  = S_RESP;
                    status_next = ST_OK;
                    cycles_next = (cnt_q == 16'hFFFF) ? 16'hFFFF : cnt_q + 16'd1;
                end else if (({1'b0, cnt_q} + 17'd1) >= TIMEOUT_LIM) begin
                    state_next     = S_DUT_RST;
                    hold_next      = HOLD_INIT;
                    after_rst_next = 1'b1;
                    status_next    = ST_TIMEOUT;
                    cycles_next    = 16'd0;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_next = cnt_q + 16'd1;
                end
            end
            S_LOAD: begin
                if (byte_valid && byte_ready) begin
                    prog_next = 1'b1;
                    addr_next = base_q + idx_q[ADDR_W-1:0];
                    data_next = byte_data;
                    idx_next  = idx_q + IDX_ONE;
                end else if ((idx_q == len_q) && !program_rom_mode) begin
                    // The last strobe is already over. Leaving now lets dut_reset_n rise
                    // one cycle after program_rom_mode has fallen.
                    state_next  = S_RESP;
                    status_next = ST_OK;
                    cycles_next = 16'(len_q);
                end
            end
            S_CLR: begin
                state_next = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next     = S_DUT_RST;
                hold_next      = HOLD_INIT;
                after_rst_next = 1'b0;
            end
        endcase

        rom_n_next     = (state_next != S_CLR);
        dut_rst_n_next = !((state_next == S_DUT_RST) || (state_next == S_LOAD));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_DUT_RST;
            hold_q           <= HOLD_INIT;
            after_rst_q      <= 1'b0;
            cnt_q            <= 16'd0;
            idx_q            <= '0;
            base_q           <= '0;
            len_q            <= '0;
            status_q         <= ST_OK;
            cycles_q         <= 16'd0;
            debug_cmd        <= 4'd0;
            program_rom_mode <= 1'b0;
            code_rom_addr_in <= '0;
            code_rom_data_in <= 8'd0;
            reset_code_rom_n <= 1'b1;
            dut_reset_n      <= 1'b0;
        end else begin
            state            <= state_next;
            hold_q           <= hold_next;
            after_rst_q      <= after_rst_next;
            cnt_q            <= cnt_next;
            idx_q            <= idx_next;
            base_q           <= base_next;
            len_q            <= len_next;
            status_q         <= status_next;
            cycles_q         <= cycles_next;
            debug_cmd        <= cmd_next;
            program_rom_mode <= prog_next;
            code_rom_addr_in <= addr_next;
            code_rom_data_in <= data_next;
            reset_code_rom_n <= rom_n_next;
            dut_reset_n      <= dut_rst_n_next;
        end
    end

endmodule

// File: tb/tb_debug_cmd_driver.sv
// Testbench for debug_cmd_driver.
// It runs a harness model and keeps an expected code-ROM image. Responses are
// predicted from the request type, the completion delay and the load length.

module tb_debug_cmd_driver;

    localparam int TO   = 16;
    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [11:0] req_base;
    logic [12:0] req_len;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  byte_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_status;
    logic [15:0] rsp_cycles;
    logic [3:0]  debug_cmd;
    logic        command_complete;
    logic        program_rom_mode;
    logic [11:0] code_rom_addr_in;
    logic [7:0]  code_rom_data_in;
    logic        reset_code_rom_n;
    logic        dut_reset_n;

    int n_cmp = 0;
    int n_bad = 0;

    int mon_cmd = 0;
    int mon_str = 0;
    int mon_clr = 0;
    int mon_rst = 0;
    int mon_overlap = 0;
    logic [7:0] rom_obs [0:4095];
    logic [7:0] rom_exp [0:4095];
    logic [7:0] load_q [$];

    always #5 clk = ~clk;

    debug_cmd_driver #(
        .TIMEOUT_CYCLES(TO),
        .RESET_HOLD_CYCLES(HOLD),
        .ADDR_W(12)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_base(req_base),
        .req_len(req_len),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .byte_data(byte_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_status(rsp_status),
        .rsp_cycles(rsp_cycles),
        .debug_cmd(debug_cmd),
        .command_complete(command_complete),
        .program_rom_mode(program_rom_mode),
        .code_rom_addr_in(code_rom_addr_in),
        .code_rom_data_in(code_rom_data_in),
        .reset_code_rom_n(reset_code_rom_n),
        .dut_reset_n(dut_reset_n)
    );

    // Harness-side observer: this is the ROM as the harness would see it, plus event tallies.
    always @(negedge clk) begin
        if (debug_cmd != 4'd0) mon_cmd <= mon_cmd + 1;
        if (!dut_reset_n) mon_rst <= mon_rst + 1;
        if ((program_rom_mode && debug_cmd != 4'd0) || (program_rom_mode && dut_reset_n))
            mon_overlap <= mon_overlap + 1;
        if (program_rom_mode) begin
            mon_str <= mon_str + 1;
            rom_obs[code_rom_addr_in] <= code_rom_data_in;
        end
        if (!reset_code_rom_n) begin
            mon_clr <= mon_clr + 1;
            for (int a = 0; a < 4096; a++) rom_obs[a] <= 8'h00;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rom();
        int diffs;
        diffs = 0;
        for (int a = 0; a < 4096; a++)
            if (rom_obs[a] !== rom_exp[a]) diffs++;
        check("rom_image", diffs, 0);
    endtask

    task automatic power_on();
        int low;
        int guard;
        int saw_rsp;
        reset = 1'b1;
        tick();
        check("rst_debug_cmd", debug_cmd, 0);
        check("rst_prog", program_rom_mode, 0);
        check("rst_addr", code_rom_addr_in, 0);
        check("rst_data", code_rom_data_in, 0);
        check("rst_rom_n", reset_code_rom_n, 1);
        check("rst_dut_n", dut_reset_n, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_byte_ready", byte_ready, 0);
        tick();
        reset = 1'b0;
        low = 0;
        guard = 0;
        saw_rsp = 0;
        while (!req_ready && guard < 50) begin
            if (!dut_reset_n) low++;
            if (rsp_valid) saw_rsp = 1;
            tick();
            guard++;
        end
        check("por_req_ready", req_ready, 1);
        check("por_rst_low_cycles", low, HOLD);
        check("por_no_rsp", saw_rsp, 0);
        check("por_dut_n_released", dut_reset_n, 1);
    endtask

    // Issues one request and plays the harness role for it. The task predicts
    // the response from the request alone and checks every observable effect.
    // d: cycles from the issue cycle until command_complete (d > TO means none).
    task automatic do_req(input logic [2:0] op, input int d, input logic [11:0] base,
                          input int len, input int gap_at);
        int guard;
        int i;
        int hold;
        int unstable;
        int load_bad;
        int gap_done;
        int c_cmd;
        int c_str;
        int c_clr;
        int c_rst;
        logic [1:0]  exp_st;
        logic [15:0] exp_cy;
        int exp_cmd;
        int exp_str;
        int exp_clr;
        int exp_rst;

        guard = 0;
        while (!req_ready && guard < 100) begin
            tick();
            guard++;
        end
        check("req_ready_idle", req_ready, 1);

        exp_cmd = 0; exp_str = 0; exp_clr = 0; exp_rst = 0;
        exp_st = 2'd0; exp_cy = 16'd0;
        case (op)
            3'd1, 3'd2, 3'd3: begin
                exp_cmd = 1;
                if (d <= TO) exp_cy = 16'(d);
                else begin
                    exp_st  = 2'd1;
                    exp_rst = HOLD;
                end
            end
            3'd4: begin
                exp_cy  = 16'(len);
                exp_str = len;
                for (int k = 0; k < len; k++) rom_exp[(int'(base) + k) % 4096] = load_q[k];
            end
            3'd5: begin
                exp_clr = 1;
                for (int a = 0; a < 4096; a++) rom_exp[a] = 8'h00;
            end
            3'd6: exp_rst = HOLD;
            default: exp_st = 2'd2;
        endcase

        c_cmd = mon_cmd; c_str = mon_str; c_clr = mon_clr; c_rst = mon_rst;

        req_valid = 1'b1;
        req_op    = op;
        req_base  = base;
        req_len   = 13'(len);
        tick();
        req_valid = 1'b0;

        load_bad = 0;
        if (op >= 3'd1 && op <= 3'd3) begin
            check("issue_cmd_value", debug_cmd, op);
            tick();
            check("issue_cmd_one_cycle", debug_cmd, 0);
            if (d <= TO) begin
                for (int k = 1; k < d; k++) tick();
                command_complete = 1'b1;
                tick();
                command_complete = 1'b0;
            end
        end else if (op == 3'd4) begin
            i = 0;
            guard = 0;
            gap_done = 0;
            while (i < len && guard < 500) begin
                guard++;
                if (dut_reset_n !== 1'b0) load_bad++;
                if ((i == gap_at && gap_done == 0) || $urandom_range(0, 3) == 0) begin
                    gap_done   = 1;
                    byte_valid = 1'b0;
                    tick();
                end else begin
                    byte_valid = 1'b1;
                    byte_data  = load_q[i];
                    if (byte_ready) begin
                        tick();
                        i++;
                    end else begin
                        tick();
                    end
                end
            end
            byte_valid = 1'b0;
            check("load_all_bytes_taken", i, len);
            check("load_byte_ready_end", byte_ready, 0);
        end

        guard = 0;
        while (!rsp_valid && guard < 100) begin
            if (op == 3'd4 && dut_reset_n !== 1'b0) load_bad++;
            tick();
            guard++;
        end
        check("rsp_arrived", rsp_valid, 1);

        unstable = 0;
        hold = $urandom_range(0, 3);
        for (int k = 0; k < hold; k++) begin
            if (rsp_valid !== 1'b1 || rsp_status !== exp_st || rsp_cycles !== exp_cy
                || req_ready !== 1'b0)
                unstable++;
            tick();
        end
        check("rsp_held_stable", unstable, 0);
        check("rsp_status", rsp_status, exp_st);
        check("rsp_cycles", rsp_cycles, exp_cy);
        check("rsp_dut_n_high", dut_reset_n, 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_dropped_after_accept", rsp_valid, 0);
        check("idle_after_rsp", req_ready, 1);

        check("cmd_pulse_count", mon_cmd - c_cmd, exp_cmd);
        check("rom_strobe_count", mon_str - c_str, exp_str);
        check("rom_clear_cycles", mon_clr - c_clr, exp_clr);
        if (op == 3'd4) check("load_dut_held", load_bad, 0);
        else check("dut_reset_low_cycles", mon_rst - c_rst, exp_rst);
        check_rom();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        reset = 1'b1;
        req_valid = 1'b0;
        req_op = 3'd0;
        req_base = 12'd0;
        req_len = 13'd0;
        byte_valid = 1'b0;
        byte_data = 8'd0;
        rsp_ready = 1'b0;
        command_complete = 1'b0;
        for (int a = 0; a < 4096; a++) rom_exp[a] = 8'h00;

        power_on();

        do_req(3'd5, 0, 12'd0, 0, -1);                    // clear ROM: known image
        do_req(3'd2, 5, 12'd0, 0, -1);                    // STEPI, complete 5 cycles later
        load_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        do_req(3'd4, 0, 12'hFFE, 4, 2);                   // LOAD wrapping past the top address
        do_req(3'd1, TO + 1, 12'd0, 0, -1);               // RUN, never completes -> TIMEOUT
        do_req(3'd1, TO, 12'd0, 0, -1);                   // complete on the timeout cycle -> OK
        do_req(3'd3, TO - 1, 12'd0, 0, -1);
        do_req(3'd1, 1, 12'd0, 0, -1);
        do_req(3'd7, 0, 12'd0, 0, -1);                    // illegal op
        do_req(3'd0, 0, 12'd0, 0, -1);
        do_req(3'd5, 0, 12'd0, 0, -1);                    // clear ROM
        do_req(3'd6, 0, 12'd0, 0, -1);                    // reset DUT
        load_q.delete();
        do_req(3'd4, 0, 12'h123, 0, -1);                  // zero-length LOAD

        for (int n = 0; n < 40; n++) begin
            int d;
            int len;
            logic [11:0] base;
            op   = $urandom_range(0, 7);
            d    = $urandom_range(1, TO + 4);
            len  = $urandom_range(0, 8);
            base = 12'($urandom_range(0, 4095));
            load_q.delete();
            for (int k = 0; k < len; k++) load_q.push_back(8'($urandom_range(0, 255)));
            do_req(3'(op), d, base, len, -1);
        end

        // Reset arrives in the middle of a LOAD, after 2 of 8 bytes.
        load_q.delete();
        for (int k = 0; k < 8; k++) load_q.push_back(8'($urandom_range(0, 255)));
        check("midload_req_ready", req_ready, 1);
        req_valid = 1'b1;
        req_op    = 3'd4;
        req_base  = 12'h100;
        req_len   = 13'd8;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("midload_byte_ready", byte_ready, 1);
            byte_valid = 1'b1;
            byte_data  = load_q[k];
            rom_exp[256 + k] = load_q[k];
            tick();
        end
        byte_valid = 1'b0;
        check("midload_strobe", program_rom_mode, 1);
        power_on();
        check_rom();
        do_req(3'd2, 3, 12'd0, 0, -1);

        check("no_overlap_events", mon_overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
